if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
//  Parametrised instruction-fetch stage; next generation of the single-cycle IF block.
//  Generates sequential fetch PCs, issues pipelined requests to instruction memory over a
//  req/gnt + rvalid handshake, and buffers responses with their PCs in a prefetch FIFO.
//  Feeds decode over valid/ready; accepts branch/jump redirects from EX with in-flight discard.
// PARAMETERS
//  ADDR_W      32      PC / memory address width
//  INST_W      32      instruction width; PC step = INST_W/8 bytes
//  RESET_PC    32'h0   first fetch address after reset
//  FIFO_DEPTH  4       prefetch entries; power of 2, >= 2; also caps outstanding requests
// PORTS
//  clk             in   1       clock, rising edge
//  rst_n           in   1       asynchronous reset, active-low
//  redirect_i      in   1       jump/branch taken; flush and refetch
//  redirect_pc_i   in   ADDR_W  redirect target
//  imem_req_o      out  1       fetch request
//  imem_addr_o     out  ADDR_W  fetch address, word-aligned
//  imem_gnt_i      in   1       request accepted in this cycle
//  imem_rvalid_i   in   1       response data valid (in order, >= 1 cycle after gnt)
//  imem_rdata_i    in   INST_W  response instruction
//  inst_valid_o    out  1       instruction available to decode
//  inst_ready_i    in   1       decode accepts instruction
//  inst_o          out  INST_W  instruction
//  inst_pc_o       out  ADDR_W  PC of inst_o
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, fetch_pc=RESET_PC, FIFO empty, outstanding=0,
//    discard=0; imem_req_o=0, imem_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, inst_pc_o=0.
//  - FSM: IDLE -> FETCH one cycle after rst_n deasserts (no request in first cycle).
//    FETCH stays FETCH; only reset returns to IDLE.
//  - Request: imem_req_o=1 in FETCH when !redirect_i and outstanding+fifo_count < FIFO_DEPTH.
//    imem_addr_o=fetch_pc. On req&gnt: fetch_pc += INST_W/8 (wraps modulo 2^ADDR_W),
//    outstanding += 1. req may drop without gnt (no stability requirement on memory side).
//  - Response: on rvalid, outstanding -= 1; if discard>0, discard -= 1 and data dropped;
//    else {pc,rdata} pushed to FIFO. Response PC = per-request PC queue (depth FIFO_DEPTH)
//    or equivalent tracking. Credit rule guarantees FIFO never overflows.
//  - Output: inst_valid_o = !fifo_empty & !redirect_i; pop on inst_valid_o & inst_ready_i.
//    Same-cycle push+pop allowed at any occupancy incl. full. Latency gnt->inst_valid_o
//    = response latency + 1 cycle (FIFO registered, no bypass).
//  - Redirect (priority over everything): FIFO cleared; fetch_pc <= {redirect_pc_i[ADDR_W-1:2],2'b0};
//    discard <= outstanding after this cycle's gnt/rvalid updates (a gnt in the redirect
//    cycle cannot occur since req=0; an rvalid in that cycle is dropped). First request at
//    the new PC in the next cycle. Back-to-back redirects: last one wins, discard accumulates.
//  - Reset mid-operation: all state cleared immediately; late rvalids after reset are the
//    memory's responsibility (memory is reset by the same rst_n).
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds outputs perf_fetch_o[31:0] (count of accepted decode
//    handshakes) and perf_stall_o[31:0] (cycles in FETCH with FIFO empty); both reset to 0,
//    wrap at 2^32, frozen during redirect cycles. Undefined: ports and counters absent.
// STRUCTURE
//  Package if_pkg: fetch_state_e {IDLE, FETCH}, localparam INST_BYTES=INST_W/8,
//    ptr width function clog2(FIFO_DEPTH).
//  Sub-module if_prefetch_fifo: sync FIFO, width ADDR_W+INST_W, depth FIFO_DEPTH,
//    with flush, count, full/empty outputs, async active-low reset.
// TESTING
//  1 Reset release, gnt=1, 1-cycle rvalid, ready=1 -> req low 1st cycle; addrs 0,4,8,..;
//    inst_pc_o 0,4,8 in order, one per cycle steady state.
//  2 ready=0 with FIFO_DEPTH=4 -> exactly 4 requests granted, req then stays 0; ready=1
//    resumes with no lost/duplicated PC.
//  3 Redirect to 0x100 with 3 outstanding -> 3 responses dropped, FIFO empty, next valid
//    inst_pc_o=0x100; redirect to 0x103 -> fetch at 0x100.
//  4 Redirect on two consecutive cycles (0x200 then 0x300) -> only 0x300 stream appears.
//  5 gnt random 50%, rvalid latency 1-3 random -> output PC stream strictly sequential,
//    matches scoreboard of memory contents.
//  6 rst_n asserted mid-stream -> outputs at reset values same cycle; restart at RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional feature macro used by if_fetch_unit: IF_PERF_CNT_EN.
package if_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

  localparam int INST_W_DEF = 32;
  localparam int INST_BYTES = INST_W_DEF / 8;

  // Pointer width for a FIFO of n entries; never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// Prefetch FIFO holding {pc, instruction} pairs: registered storage, synchronous
// flush, and push+pop in the same cycle at any occupancy including full.
module if_prefetch_fifo
  import if_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = DEPTH[CNT_W-1:0];
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees the slot this cycle, so a push into a full FIFO is fine then.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: pipelined req/gnt + rvalid fetch into a prefetch FIFO,
// valid/ready to decode, redirects with in-flight discard. Macro: IF_PERF_CNT_EN.
//
// Handshakes: memory request is accepted when imem_req_o & imem_gnt_i in a cycle;
// each accepted request returns exactly one imem_rvalid_i pulse, in order; decode
// takes an instruction when inst_valid_o & inst_ready_i in a cycle.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                INST_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_o,
  output logic [31:0]       perf_stall_o
`endif
);

  localparam int PTR_W  = clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SUM_W  = PTR_W + 2;
  localparam int FIFO_W = ADDR_W + INST_W;
  localparam int STEP   = (INST_W == INST_W_DEF) ? INST_BYTES : INST_W / 8;

  localparam logic [ADDR_W-1:0] PC_STEP      = ADDR_W'(STEP);
  localparam logic [SUM_W-1:0]  CREDIT_LIMIT = SUM_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  discard_q, discard_d;

  logic [ADDR_W-1:0] redirect_pc_aligned;
  logic [SUM_W-1:0]  credit_used;
  logic              req;
  logic              req_accept;
  logic              resp_keep;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [FIFO_W-1:0] fifo_wdata;
  logic [FIFO_W-1:0] fifo_rdata;

  assign redirect_pc_aligned = {redirect_pc_i[ADDR_W-1:2], 2'b00};

  // Every request in flight owns a FIFO slot, so responses can never overflow it.
  assign credit_used = SUM_W'(outstanding_q) + SUM_W'(fifo_count);
  assign req = (state_q == FETCH) && !redirect_i && !fifo_full &&
               (credit_used < CREDIT_LIMIT);
  assign req_accept = req && imem_gnt_i;

  assign resp_keep  = imem_rvalid_i && (discard_q == '0);
  assign fifo_push  = resp_keep && !redirect_i;
  assign fifo_wdata = {resp_pc_q, imem_rdata_i};

  always_comb begin
    state_d       = (state_q == IDLE) ? FETCH : state_q;
    fetch_pc_d    = req_accept ? (fetch_pc_q + PC_STEP) : fetch_pc_q;
    outstanding_d = outstanding_q + CNT_W'(req_accept) - CNT_W'(imem_rvalid_i);
    discard_d     = discard_q;
    resp_pc_d     = resp_pc_q;
    if (imem_rvalid_i && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
    if (resp_keep) resp_pc_d = resp_pc_q + PC_STEP;
    // Whatever is still in flight after this cycle belongs to the old stream.
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_aligned;
      resp_pc_d  = redirect_pc_aligned;
      discard_d  = outstanding_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  if_prefetch_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_i),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign imem_req_o   = req;
  assign imem_addr_o  = fetch_pc_q;
  assign inst_valid_o = !fifo_empty && !redirect_i;
  assign fifo_pop     = inst_valid_o && inst_ready_i;
  assign inst_pc_o    = fifo_rdata[FIFO_W-1:INST_W];
  assign inst_o       = fifo_rdata[INST_W-1:0];

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Both counters hold their value in redirect cycles.
  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_stall_d = perf_stall_q;
    if (!redirect_i) begin
      if (fifo_pop) perf_fetch_d = perf_fetch_q + 32'd1;
      if ((state_q == FETCH) && fifo_empty) perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_o = perf_fetch_q;
  assign perf_stall_o = perf_stall_q;
`else
  // Without the counters the stage has no extra state or ports.
`endif

endmodule
